sprite_frame_sequencer: RTL and testbench

- Frame-level scheduler between the per-sprite pixel walker (draw_bird-style: anchor in, one pixel per cycle out, `done` when finished) and the VGA adapter plot port.
- On each frame tick it visits every enabled sprite slot in index order. For each slot it erases the slot at its previously drawn anchor, then draws it at the newly sampled anchor.
- It forwards the walker's pixels with the correct colour and `plot` strobe.
- It replaces the hard-wired ERASE/DRAW state pairs in the top level.

---
 rtl/duck_hunt_pkg.sv | 40 ++++
 rtl/sprite_frame_sequencer_next_slot_finder.sv | 36 +++
 rtl/sprite_frame_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_sprite_frame_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duck_hunt_pkg.sv
// ============================================================================
// Module      : duck_hunt_pkg
// Description : Shared constants, colours and sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package duck_hunt_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] WHITE  = 3'b111;
    localparam logic [2:0] HUNTER = 3'b001;
    localparam logic [2:0] LASER  = 3'b010;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_LATCH       = 3'd1;
    localparam logic [2:0] ST_ERASE_START = 3'd2;
    localparam logic [2:0] ST_ERASE_WAIT  = 3'd3;
    localparam logic [2:0] ST_DRAW_START  = 3'd4;
    localparam logic [2:0] ST_DRAW_WAIT   = 3'd5;
    localparam logic [2:0] ST_NEXT        = 3'd6;
    localparam logic [2:0] ST_DONE        = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE        = ST_IDLE,
        S_LATCH       = ST_LATCH,
        S_ERASE_START = ST_ERASE_START,
        S_ERASE_WAIT  = ST_ERASE_WAIT,
        S_DRAW_START  = ST_DRAW_START,
        S_DRAW_WAIT   = ST_DRAW_WAIT,
        S_NEXT        = ST_NEXT,
        S_DONE        = ST_DONE
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/sprite_frame_sequencer_next_slot_finder.sv
// ============================================================================
// Module      : next_slot_finder
// Description : Lowest enabled slot index strictly above cur (or from 0 when
//               first is set), with a none flag when no such slot exists.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module next_slot_finder
    import duck_hunt_pkg::*;
#(
    parameter int NUM_SLOTS = 6,
    parameter int IDX_W     = 3
) (
    input  logic [NUM_SLOTS-1:0] mask,
    input  logic [IDX_W-1:0]     cur,
    input  logic                 first,
    output logic [IDX_W-1:0]     next,
    output logic                 none
);

    // Descending scan so the lowest qualifying index is the last one written.
    always_comb begin
        next = '0;
        none = 1'b1;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur)))) begin
                next = IDX_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sprite_frame_sequencer.sv
// ============================================================================
// Module      : sprite_frame_sequencer
// Description : Per-frame erase/redraw scheduler between the sprite pixel
//               walker and the VGA plot port. Optional macro PLOT_CLIP_EN
//               suppresses off-screen pixels and adds clipped_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_frame_sequencer
    import duck_hunt_pkg::*;
#(
    parameter int         NUM_SLOTS    = 6,
    parameter logic [2:0] ERASE_COLOUR = BLACK,
    parameter int         X_W          = 8,
    parameter int         Y_W          = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic [NUM_SLOTS-1:0]   slot_en,
    input  logic [NUM_SLOTS*X_W-1:0] slot_x,
    input  logic [NUM_SLOTS*Y_W-1:0] slot_y,
    input  logic [NUM_SLOTS*3-1:0] slot_colour,
    input  logic                   walk_done,
    input  logic [X_W-1:0]         walk_x,
    input  logic [Y_W-1:0]         walk_y,
    output logic                   walk_reset,
    output logic [X_W-1:0]         anchor_x,
    output logic [Y_W-1:0]         anchor_y,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [2:0]             colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   frame_done,
`ifdef PLOT_CLIP_EN
    output logic [15:0]            clipped_cnt,
`endif
    output logic                   overrun
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    seq_state_t           r_state;
    logic [IDX_W-1:0]     r_slot;
    logic [NUM_SLOTS-1:0] r_en;
    logic [NUM_SLOTS-1:0] r_prev_valid;
    logic [X_W-1:0]       r_new_x  [NUM_SLOTS];
    logic [Y_W-1:0]       r_new_y  [NUM_SLOTS];
    logic [2:0]           r_new_c  [NUM_SLOTS];
    logic [X_W-1:0]       r_prev_x [NUM_SLOTS];
    logic [Y_W-1:0]       r_prev_y [NUM_SLOTS];
    logic                 r_walk_reset;
    logic [X_W-1:0]       r_anchor_x;
    logic [Y_W-1:0]       r_anchor_y;
    logic [2:0]           r_colour;
    logic                 r_busy;
    logic                 r_frame_done;
    logic                 r_overrun;

    logic [IDX_W-1:0]     w_next;
    logic                 w_none;
    logic                 w_wait;
    logic                 w_in_range;
    logic                 w_plot;

    next_slot_finder #(
        .NUM_SLOTS (NUM_SLOTS),
        .IDX_W     (IDX_W)
    ) u_finder (
        .mask  (r_en),
        .cur   (r_slot),
        .first (r_state == S_LATCH),
        .next  (w_next),
        .none  (w_none)
    );

`ifdef PLOT_CLIP_EN
    logic [15:0] r_clipped;

    assign w_in_range = (32'(walk_x) < SCREEN_W) && (32'(walk_y) < SCREEN_H);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clipped <= '0;
        end else if (w_wait && !walk_done && !w_in_range && (r_clipped != 16'hFFFF)) begin
            r_clipped <= r_clipped + 16'd1;
        end
    end

    assign clipped_cnt = r_clipped;
`else
    assign w_in_range = 1'b1;
`endif

    assign w_wait = (r_state == S_ERASE_WAIT) || (r_state == S_DRAW_WAIT);
    assign w_plot = w_wait && !walk_done && w_in_range;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_slot       <= '0;
            r_en         <= '0;
            r_prev_valid <= '0;
            r_walk_reset <= 1'b0;
            r_anchor_x   <= '0;
            r_anchor_y   <= '0;
            r_colour     <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_new_x[i]  <= '0;
                r_new_y[i]  <= '0;
                r_new_c[i]  <= '0;
                r_prev_x[i] <= '0;
                r_prev_y[i] <= '0;
            end
        end else begin
            r_walk_reset <= 1'b0;
            r_frame_done <= 1'b0;
            if (frame_tick && r_busy) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (frame_tick) begin
                        r_state <= S_LATCH;
                        r_busy  <= 1'b1;
                        r_en    <= slot_en;
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            r_new_x[i] <= slot_x[i*X_W +: X_W];
                            r_new_y[i] <= slot_y[i*Y_W +: Y_W];
                            r_new_c[i] <= slot_colour[i*3 +: 3];
                        end
                    end
                end
                // A slot never drawn before has nothing to erase, so it goes
                // straight to its draw pass without spending an erase cycle.
                S_LATCH, S_NEXT: begin
                    if (w_none) begin
                        r_state      <= S_DONE;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_slot       <= w_next;
                        r_walk_reset <= 1'b1;
                        if (r_prev_valid[w_next]) begin
                            r_state    <= S_ERASE_START;
                            r_anchor_x <= r_prev_x[w_next];
                            r_anchor_y <= r_prev_y[w_next];
                        end else begin
                            r_state    <= S_DRAW_START;
                            r_anchor_x <= r_new_x[w_next];
                            r_anchor_y <= r_new_y[w_next];
                        end
                    end
                end
                S_ERASE_START: begin
                    r_state  <= S_ERASE_WAIT;
                    r_colour <= ERASE_COLOUR;
                end
                S_ERASE_WAIT: begin
                    if (walk_done) begin
                        r_state      <= S_DRAW_START;
                        r_walk_reset <= 1'b1;
                        r_anchor_x   <= r_new_x[r_slot];
                        r_anchor_y   <= r_new_y[r_slot];
                        r_colour     <= '0;
                    end
                end
                S_DRAW_START: begin
                    r_state  <= S_DRAW_WAIT;
                    r_colour <= r_new_c[r_slot];
                end
                S_DRAW_WAIT: begin
                    if (walk_done) begin
                        r_state              <= S_NEXT;
                        r_prev_x[r_slot]     <= r_new_x[r_slot];
                        r_prev_y[r_slot]     <= r_new_y[r_slot];
                        r_prev_valid[r_slot] <= 1'b1;
                        r_colour             <= '0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign walk_reset = r_walk_reset;
    assign anchor_x   = r_anchor_x;
    assign anchor_y   = r_anchor_y;
    assign plot       = w_plot;
    assign x          = w_plot ? walk_x : '0;
    assign y          = w_plot ? walk_y : '0;
    assign colour     = r_colour;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_sprite_frame_sequencer.sv
// ============================================================================
// Module      : tb_sprite_frame_sequencer
// Description : Self-checking bench with a 13-pixel walker model and a
//               frame-level reference model of the erase/redraw schedule.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_frame_sequencer;

    localparam int NS = 6;

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } pix_t;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            frame_tick = 1'b0;
    logic [NS-1:0]   slot_en = '0;
    logic [NS*8-1:0] slot_x = '0;
    logic [NS*7-1:0] slot_y = '0;
    logic [NS*3-1:0] slot_colour = '0;
    logic            walk_done;
    logic [7:0]      walk_x;
    logic [6:0]      walk_y;
    logic            walk_reset;
    logic [7:0]      anchor_x;
    logic [6:0]      anchor_y;
    logic [7:0]      x;
    logic [6:0]      y;
    logic [2:0]      colour;
    logic            plot;
    logic            busy;
    logic            frame_done;
    logic            overrun;
`ifdef PLOT_CLIP_EN
    logic [15:0]     clipped_cnt;
`endif

    sprite_frame_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .slot_en     (slot_en),
        .slot_x      (slot_x),
        .slot_y      (slot_y),
        .slot_colour (slot_colour),
        .walk_done   (walk_done),
        .walk_x      (walk_x),
        .walk_y      (walk_y),
        .walk_reset  (walk_reset),
        .anchor_x    (anchor_x),
        .anchor_y    (anchor_y),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .busy        (busy),
        .frame_done  (frame_done),
`ifdef PLOT_CLIP_EN
        .clipped_cnt (clipped_cnt),
`endif
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    // Bird shape walked from the anchor: 13 pixels, first (0,0), last (-5,-3).
    int DX [14] = '{0, -1, -2, -3, -4, -5, -5, -4, -3, -3, -4, -5, -5, 0};
    int DY [14] = '{0,  0,  0,  0,  0,  0, -1, -1, -1, -2, -2, -2, -3, 0};

    logic [7:0] wk_ax  = '0;
    logic [6:0] wk_ay  = '0;
    logic [3:0] wk_idx = 4'd13;

    always @(posedge clock) begin
        if (walk_reset) begin
            wk_ax  <= anchor_x;
            wk_ay  <= anchor_y;
            wk_idx <= 4'd0;
        end else if (wk_idx != 4'd13) begin
            wk_idx <= wk_idx + 4'd1;
        end
    end

    assign walk_done = (wk_idx == 4'd13);
    assign walk_x    = wk_ax + 8'(DX[wk_idx]);
    assign walk_y    = wk_ay + 7'(DY[wk_idx]);

    int checks   = 0;
    int failures = 0;

    // Reference model: what has been drawn where, per slot
    logic       m_pv [NS];
    logic [7:0] m_px [NS];
    logic [6:0] m_py [NS];
    logic       m_ovr;

    pix_t        exp_pix [$];
    pix_t        obs_pix [$];
    logic [14:0] exp_rst [$];
    logic [14:0] obs_rst [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic on_screen(input logic [7:0] px, input logic [6:0] py);
`ifdef PLOT_CLIP_EN
        return (px < 8'd160) && (py < 7'd120);
`else
        return 1'b1;
`endif
    endfunction

    task automatic push_sprite(input logic [7:0] ax, input logic [6:0] ay, input logic [2:0] c);
        for (int k = 0; k < 13; k++) begin
            pix_t p;
            p.px = ax + 8'(DX[k]);
            p.py = ay + 7'(DY[k]);
            p.pc = c;
            if (on_screen(p.px, p.py)) exp_pix.push_back(p);
        end
    endtask

    task automatic set_slot(input int s, input logic [7:0] sx, input logic [6:0] sy, input logic [2:0] c);
        slot_x[s*8 +: 8]      = sx;
        slot_y[s*7 +: 7]      = sy;
        slot_colour[s*3 +: 3] = c;
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_pv[s] = 1'b0;
            m_px[s] = '0;
            m_py[s] = '0;
        end
        m_ovr = 1'b0;
    endtask

    task automatic run_frame(input int extra_tick);
        int lat;
        int done_at;
        logic busy_at_done;
        exp_pix.delete();
        exp_rst.delete();
        obs_pix.delete();
        obs_rst.delete();
        lat = 2;
        for (int s = 0; s < NS; s++) begin
            if (slot_en[s]) begin
                if (m_pv[s]) begin
                    exp_rst.push_back({m_px[s], m_py[s]});
                    push_sprite(m_px[s], m_py[s], 3'b000);
                    lat += 15;
                end
                exp_rst.push_back({slot_x[s*8 +: 8], slot_y[s*7 +: 7]});
                push_sprite(slot_x[s*8 +: 8], slot_y[s*7 +: 7], slot_colour[s*3 +: 3]);
                lat += 16;
                m_pv[s] = 1'b1;
                m_px[s] = slot_x[s*8 +: 8];
                m_py[s] = slot_y[s*7 +: 7];
            end
        end
        if (extra_tick > 0) m_ovr = 1'b1;

        @(negedge clock);
        frame_tick = 1'b1;
        done_at = 0;
        busy_at_done = 1'b0;
        for (int n = 1; n <= 600; n++) begin
            @(negedge clock);
            frame_tick = (n == extra_tick);
            if (n == 1) check("busy_in_latch", 32'(busy), 32'd1);
            if (plot) obs_pix.push_back({x, y, colour});
            if (walk_reset) obs_rst.push_back({anchor_x, anchor_y});
            if (frame_done) begin
                done_at = n;
                busy_at_done = busy;
                break;
            end
        end
        frame_tick = 1'b0;
        check("frame_done_latency", 32'(done_at), 32'(lat));
        check("busy_at_done", 32'(busy_at_done), 32'd1);
        @(negedge clock);
        check("busy_after_done", 32'(busy), 32'd0);
        check("frame_done_pulse", 32'(frame_done), 32'd0);
        check("pixel_count", 32'(obs_pix.size()), 32'(exp_pix.size()));
        for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++)
            check($sformatf("pixel[%0d]", i), 32'(obs_pix[i]), 32'(exp_pix[i]));
        check("walk_reset_count", 32'(obs_rst.size()), 32'(exp_rst.size()));
        for (int i = 0; i < exp_rst.size() && i < obs_rst.size(); i++)
            check($sformatf("anchor[%0d]", i), 32'(obs_rst[i]), 32'(exp_rst[i]));
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_plot"}, 32'(plot), 32'd0);
        check({tag, "_xy"}, 32'({x, y}), 32'd0);
        check({tag, "_colour"}, 32'(colour), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_walk_reset"}, 32'(walk_reset), 32'd0);
        check({tag, "_anchor"}, 32'({anchor_x, anchor_y}), 32'd0);
    endtask

    initial begin
        int guard;
        model_reset();

        // Reset state and idle behaviour
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            check("idle_plot_busy_ovr", 32'({plot, busy, overrun}), 32'd0);
        end

        // First frame: slot 0 only, nothing to erase
        slot_en = 6'b000001;
        set_slot(0, 8'd5, 7'd7, 3'b111);
        run_frame(0);
        check("f1_first_pixel", 32'(obs_pix.size() > 0 ? obs_pix[0] : pix_t'(0)), 32'({8'd5, 7'd7, 3'b111}));
        check("f1_last_pixel", 32'(obs_pix.size() > 0 ? obs_pix[obs_pix.size()-1] : pix_t'(0)),
              32'({8'd0, 7'd4, 3'b111}));

        // Second frame: slot 0 moves, erase then redraw (33-cycle frame)
        set_slot(0, 8'd6, 7'd7, 3'b111);
        run_frame(0);

        // Sparse enables: slots 2 then 5 only
        slot_en = 6'b100100;
        set_slot(2, 8'($urandom_range(5, 150)), 7'($urandom_range(3, 110)), 3'($urandom_range(1, 7)));
        set_slot(5, 8'($urandom_range(5, 150)), 7'($urandom_range(3, 110)), 3'($urandom_range(1, 7)));
        run_frame(0);
        check("sparse_resets", 32'(obs_rst.size()), 32'd2);

        // Tick while busy is dropped and overrun sticks
        slot_en = 6'b000001;
        set_slot(0, 8'd40, 7'd30, 3'b011);
        run_frame(7);
        slot_en = 6'b100101;
        run_frame(0);

        // Asynchronous reset during a draw pass
        slot_en = 6'b000001;
        set_slot(0, 8'd50, 7'd50, 3'b101);
        @(negedge clock);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        guard = 0;
        while (!(plot && colour == 3'b101) && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        check("reached_draw_wait", 32'(guard < 200), 32'd1);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        slot_en = 6'b000011;
        set_slot(1, 8'd90, 7'd60, 3'b110);
        run_frame(0);

        // Randomised frames against the reference model
        for (int f = 0; f < 5; f++) begin
            slot_en = 6'($urandom);
            for (int s = 0; s < NS; s++)
                set_slot(s, 8'($urandom), 7'($urandom), 3'($urandom));
            run_frame(0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
